// File: rtl/clk_time_uart_tx.sv
// clk_time_uart_tx: serial time reporter for the 12-hour BCD clock.
// Each seconds change (while ena=1) snapshots pm/hh/mm/ss and sends the line
// "HH:MM:SSAM\r\n" or "HH:MM:SSPM\r\n" as 8N1 UART bytes on txd.
// A trigger that arrives while a frame is in flight is held in a one-deep
// pending slot; only the latest such snapshot is kept.
// Optional build macro: CLK_TX_ZERO_BLANK_EN -- a leading hour digit of 0 is
// sent as a space instead of '0'. Frame length is unchanged.
//
// Handshake: the block has no valid/ready channel. busy is high from the first
// start-bit cycle up to the cycle frame_done pulses; frame_done is a one-cycle
// pulse coincident with busy falling. dbg_state exposes the FSM state encoding.
module clk_time_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    output logic       txd,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] dbg_state
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // NEXT is the one-cycle frame priming state between a capture and the
    // first start bit; consecutive bytes inside a frame run back to back.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEXT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_txd;
    logic             r_busy;
    logic             r_frame_done;
    logic [7:0]       r_prev_ss;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_byte_idx;

    logic             r_snap_pm;
    logic [7:0]       r_snap_hh;
    logic [7:0]       r_snap_mm;
    logic [7:0]       r_snap_ss;

    logic             r_pending;
    logic             r_pend_pm;
    logic [7:0]       r_pend_hh;
    logic [7:0]       r_pend_mm;
    logic [7:0]       r_pend_ss;

    logic             w_trig;
    logic             w_bit_end;
    logic             w_frame_end;
    logic [7:0]       w_byte;

    // BCD nibble to ASCII; anything above 9 is shown as '?'.
    function automatic logic [7:0] f_digit(input logic [3:0] n);
        f_digit = (n > 4'd9) ? 8'h3F : {4'h3, n};
    endfunction

    assign w_trig      = ena && (ss != r_prev_ss);
    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_byte_idx == 4'd11);

    // Character selected by the byte index from the active snapshot.
    always_comb begin
        w_byte = 8'h0A;
        unique case (r_byte_idx)
`ifdef CLK_TX_ZERO_BLANK_EN
            4'd0:    w_byte = (r_snap_hh[7:4] == 4'd0) ? 8'h20 : f_digit(r_snap_hh[7:4]);
`else
            4'd0:    w_byte = f_digit(r_snap_hh[7:4]);
`endif
            4'd1:    w_byte = f_digit(r_snap_hh[3:0]);
            4'd2:    w_byte = 8'h3A;
            4'd3:    w_byte = f_digit(r_snap_mm[7:4]);
            4'd4:    w_byte = f_digit(r_snap_mm[3:0]);
            4'd5:    w_byte = 8'h3A;
            4'd6:    w_byte = f_digit(r_snap_ss[7:4]);
            4'd7:    w_byte = f_digit(r_snap_ss[3:0]);
            4'd8:    w_byte = r_snap_pm ? 8'h50 : 8'h41;
            4'd9:    w_byte = 8'h4D;
            4'd10:   w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    // Trigger detection, snapshot capture and the UART frame sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_prev_ss    <= 8'h00;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 4'd0;
            r_snap_pm    <= 1'b0;
            r_snap_hh    <= 8'h00;
            r_snap_mm    <= 8'h00;
            r_snap_ss    <= 8'h00;
            r_pending    <= 1'b0;
            r_pend_pm    <= 1'b0;
            r_pend_hh    <= 8'h00;
            r_pend_mm    <= 8'h00;
            r_pend_ss    <= 8'h00;
        end else begin
            r_prev_ss    <= ss;
            r_frame_done <= 1'b0;

            // A trigger during a frame overwrites the pending slot. The final
            // stop-bit edge is handled below so the new time starts directly.
            if (w_trig && (r_state != ST_IDLE) && !w_frame_end) begin
                r_pend_pm <= pm;
                r_pend_hh <= hh;
                r_pend_mm <= mm;
                r_pend_ss <= ss;
                r_pending <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_snap_pm  <= pm;
                        r_snap_hh  <= hh;
                        r_snap_mm  <= mm;
                        r_snap_ss  <= ss;
                        r_pending  <= 1'b0;
                        r_byte_idx <= 4'd0;
                        r_state    <= ST_NEXT;
                    end else if (r_pending) begin
                        r_snap_pm  <= r_pend_pm;
                        r_snap_hh  <= r_pend_hh;
                        r_snap_mm  <= r_pend_mm;
                        r_snap_ss  <= r_pend_ss;
                        r_pending  <= 1'b0;
                        r_byte_idx <= 4'd0;
                        r_state    <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_txd   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_txd     <= w_byte[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= w_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_byte_idx == 4'd11) begin
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_byte_idx   <= 4'd0;
                            if (w_trig) begin
                                r_snap_pm <= pm;
                                r_snap_hh <= hh;
                                r_snap_mm <= mm;
                                r_snap_ss <= ss;
                                r_pending <= 1'b0;
                                r_state   <= ST_NEXT;
                            end else if (r_pending) begin
                                r_snap_pm <= r_pend_pm;
                                r_snap_hh <= r_pend_hh;
                                r_snap_mm <= r_pend_mm;
                                r_snap_ss <= r_pend_ss;
                                r_pending <= 1'b0;
                                r_state   <= ST_NEXT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_txd      <= 1'b0;
                            r_state    <= ST_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd        = r_txd;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_clk_time_uart_tx.sv
// Bench for clk_time_uart_tx: a cycle-level reference computed from frame
// start times and character positions, a UART line decoder, directed cases
// and a randomized phase.
module tb_clk_time_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 120 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       pm = 1'b0;
  logic [7:0] hh = 8'h12;
  logic [7:0] mm = 8'h00;
  logic [7:0] ss = 8'h00;
  logic       txd;
  logic       busy;
  logic       frame_done;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  string hr9;

  clk_time_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .pm         (pm),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_digit(input logic [3:0] n);
    if (n <= 4'd9) return 8'd48 + {4'd0, n};
    return 8'h3F;
  endfunction

  // snapshot layout: {pm, hh, mm, ss}
  function automatic logic [7:0] m_char(input logic [24:0] s, input int idx);
    logic [7:0] l [12];
    l[0] = m_digit(s[23:20]);
`ifdef CLK_TX_ZERO_BLANK_EN
    if (s[23:20] == 4'd0) l[0] = 8'h20;
`endif
    l[1]  = m_digit(s[19:16]);
    l[2]  = 8'h3A;
    l[3]  = m_digit(s[15:12]);
    l[4]  = m_digit(s[11:8]);
    l[5]  = 8'h3A;
    l[6]  = m_digit(s[7:4]);
    l[7]  = m_digit(s[3:0]);
    l[8]  = s[24] ? 8'h50 : 8'h41;
    l[9]  = 8'h4D;
    l[10] = 8'h0D;
    l[11] = 8'h0A;
    return l[idx];
  endfunction

  int         cyc = 0;
  int         m_t0 = 0;
  bit         m_active = 1'b0;
  bit         m_pend = 1'b0;
  logic [24:0] m_snap, m_pend_snap, m_cur;
  logic [7:0] m_prev_ss = 8'h00;
  logic       m_trig;
  logic       e_txd = 1'b1, e_busy = 1'b0, e_fd = 1'b0;
  int         m_off, m_bidx, m_pos;

  // A frame owns edges (t0-1 .. t0+FRAME]; txd/busy follow from the offset
  // into the frame, frame_done is the edge at t0+FRAME.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active  = 1'b0;
      m_pend    = 1'b0;
      m_prev_ss = 8'h00;
      e_txd     = 1'b1;
      e_busy    = 1'b0;
      e_fd      = 1'b0;
    end else begin
      cyc++;
      m_trig = (ss != m_prev_ss) && ena;
      m_cur  = {pm, hh, mm, ss};
      e_fd   = 1'b0;
      if (m_active && cyc == m_t0 + FRAME) begin
        e_fd     = 1'b1;
        m_active = 1'b0;
        if (m_trig) begin
          m_snap = m_cur; m_pend = 1'b0; m_t0 = cyc + 1; m_active = 1'b1;
        end else if (m_pend) begin
          m_snap = m_pend_snap; m_pend = 1'b0; m_t0 = cyc + 1; m_active = 1'b1;
        end
      end else if (m_active) begin
        if (m_trig) begin
          m_pend_snap = m_cur; m_pend = 1'b1;
        end
      end else if (m_trig) begin
        m_snap = m_cur; m_t0 = cyc + 1; m_active = 1'b1;
      end
      m_prev_ss = ss;
      if (m_active && cyc >= m_t0) begin
        m_off  = cyc - m_t0;
        m_bidx = m_off / (10 * C);
        m_pos  = (m_off % (10 * C)) / C;
        e_busy = 1'b1;
        if (m_pos == 0)      e_txd = 1'b0;
        else if (m_pos == 9) e_txd = 1'b1;
        else                 e_txd = m_char(m_snap, m_bidx)[m_pos - 1];
      end else begin
        e_busy = 1'b0;
        e_txd  = 1'b1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en && reset) begin
      check("cyc_txd",        {31'd0, txd},        {31'd0, e_txd});
      check("cyc_busy",       {31'd0, busy},       {31'd0, e_busy});
      check("cyc_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    end
  end

  // ---------------- UART line decoder ----------------
  logic [7:0] rx_q [$];
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_sh  = 8'h00;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (txd == 1'b0) begin
        rx_act = 1'b1; rx_cnt = 0; rx_bit = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == C) begin
        rx_cnt = 0;
        rx_bit++;
        if (rx_bit <= 8) rx_sh[rx_bit - 1] = txd;
        else begin
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  end

  // ---------------- driver / sequencing tasks ----------------
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((m_active || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_timeout"}, {31'd0, (k >= 3000)}, 32'd0);
  endtask

  task automatic check_line(input string name, input string txt);
    int k;
    logic [7:0] got;
    k = 0;
    while (rx_q.size() < 12 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_rx_timeout"}, {31'd0, (k >= 2000)}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
      if (i < 10) check($sformatf("%s_char%0d", name, i), {24'd0, got}, {24'd0, txt[i]});
      else        check($sformatf("%s_char%0d", name, i), {24'd0, got}, (i == 10) ? 32'h0D : 32'h0A);
    end
  endtask

  task automatic check_model(input string name, input logic [24:0] s, input string txt);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_model%0d", name, i), {24'd0, m_char(s, i)}, {24'd0, txt[i]});
  endtask

  task automatic set_ss(input logic [7:0] v);
    @(negedge clk);
    ss = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, fdc, k;
`ifdef CLK_TX_ZERO_BLANK_EN
    hr9 = " 9";
`else
    hr9 = "09";
`endif
    // model pinned against hand-written lines
    check_model("m_1200", {1'b0, 8'h12, 8'h00, 8'h01}, "12:00:01AM");
    check_model("m_0905", {1'b1, 8'h09, 8'h05, 8'h07}, {hr9, ":05:07PM"});
    check_model("m_1a",   {1'b1, 8'h1A, 8'h05, 8'h09}, "1?:05:09PM");

    // reset state
    repeat (3) @(negedge clk);
    check("rst_txd",  {31'd0, txd},        32'd1);
    check("rst_busy", {31'd0, busy},       32'd0);
    check("rst_fd",   {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ena   = 1'b1;
    cmp_en = 1'b1;
    repeat (10) @(negedge clk);
    check("no_frame_before_change", {31'd0, busy}, 32'd0);

    // 12:00:00 AM -> 01: latency, length, single frame_done
    set_ss(8'h01);
    @(negedge clk);
    check("lat_edgeN_busy", {31'd0, busy}, 32'd0);
    check("lat_edgeN_txd",  {31'd0, txd},  32'd1);
    @(negedge clk);
    check("lat_edgeN1_busy", {31'd0, busy}, 32'd1);
    check("lat_edgeN1_txd",  {31'd0, txd},  32'd0);
    len = 1; fdc = 0;
    while (busy && len < 2000) begin
      @(negedge clk);
      if (frame_done) fdc++;
      if (busy) len++;
    end
    check("frame_len", len, FRAME);
    check("fd_with_busy_fall", {31'd0, frame_done}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      if (frame_done) fdc++;
    end
    check("fd_count", fdc, 32'd1);
    check_line("line_1200", "12:00:01AM");

    // 09:05:07 PM
    @(negedge clk);
    hh = 8'h09; mm = 8'h05; pm = 1'b1; ss = 8'h07;
    wait_idle("t0905");
    check_line("line_0905", {hr9, ":05:07PM"});

    // two changes while busy -> exactly one extra frame with the latest value
    set_ss(8'h08);
    repeat (100) @(negedge clk);
    ss = 8'h02;
    repeat (50) @(negedge clk);
    ss = 8'h03;
    k = 0;
    while (!frame_done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("pend_fd_timeout", {31'd0, (k >= 1000)}, 32'd0);
    check("pend_busy_low_at_fd", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("pend_start_busy", {31'd0, busy}, 32'd1);
    check("pend_start_txd",  {31'd0, txd},  32'd0);
    wait_idle("pend");
    check_line("line_pend1", {hr9, ":05:08PM"});
    check_line("line_pend2", {hr9, ":05:03PM"});
    repeat (600) @(negedge clk);
    check("pend_no_third", rx_q.size(), 32'd0);

    // ena=0 suppresses triggers; toggling ena mid-frame leaves it intact
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ss = 8'h20 + 8'(i);
      repeat (30) @(negedge clk);
    end
    ss = 8'h10;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check("ena0_busy", {31'd0, busy}, 32'd0);
    check("ena0_txd",  {31'd0, txd},  32'd1);
    check("ena0_rx",   rx_q.size(),   32'd0);
    ss = 8'h11;
    repeat (100) @(negedge clk);
    ena = 1'b0;
    repeat (100) @(negedge clk);
    ena = 1'b1;
    wait_idle("ena");
    check_line("line_ena", {hr9, ":05:11PM"});

    // reset in the middle of byte 5
    @(negedge clk);
    hh = 8'h12; mm = 8'h34; pm = 1'b0; ss = 8'h45;
    repeat (2) @(negedge clk);
    repeat (220) @(negedge clk);
    #2;
    reset = 1'b0;
    hh = 8'h12; mm = 8'h00; pm = 1'b0; ss = 8'h00;
    #1;
    check("midrst_txd",  {31'd0, txd},  32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rx_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_rx",   rx_q.size(),   32'd0);
    set_ss(8'h01);
    wait_idle("postrst");
    check_line("line_postrst", "12:00:01AM");

    // hour nibble above 9
    @(negedge clk);
    hh = 8'h1A; mm = 8'h05; pm = 1'b1; ss = 8'h09;
    wait_idle("t1a");
    check_line("line_1a", "1?:05:09PM");

    // randomized phase, checked every cycle by the model
    for (int it = 0; it < 16; it++) begin
      @(negedge clk);
      ena = ($urandom_range(0, 3) != 0);
      pm  = 1'($urandom_range(0, 1));
      hh  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                        : {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      mm  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                        : {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      ss  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                        : {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      repeat ($urandom_range(1, 700)) @(negedge clk);
    end
    ena = 1'b1;
    wait_idle("rand");
    repeat (10) @(negedge clk);
    rx_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_time_uart_tx.md
# clk_time_uart_tx

Serial time reporter for the 12-hour BCD clock. It watches the clock's `hh`/`mm`/`ss`/`pm` outputs and, on every seconds change, snapshots the time. It then transmits the snapshot as a 12-character ASCII line (`HH:MM:SSAM\r\n` or `...PM\r\n`) on a UART 8N1 line. It sits beside the clock counter as the consumer end of its time-display interface and drives the board's debug UART.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (868 gives 115200 baud at 100 MHz); legal range is 2 or more.
- `clk`  in  1  system clock; every register uses its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ena`  in  1  clock-running indication, the same signal that drives the clock counter; only gates capture, as defined below.
- `pm`  in  1  1 means PM, 0 means AM.
- `hh`  in  8  hours as two BCD digits, 01–12.
- `mm`  in  8  minutes as two BCD digits, 00–59.
- `ss`  in  8  seconds as two BCD digits, 00–59.
- `txd`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a frame is being transmitted.
- `frame_done`  out  1  one-cycle pulse when the stop bit of the final LF completes.

## Operation
- Reset state:
  - `txd`=1, `busy`=0, `frame_done`=0.
  - `prev_ss`=8'h00, pending flag=0, FSM=IDLE.
- Trigger:
  - Each cycle the block registers `ss` into `prev_ss`.
  - A trigger fires when `ss != prev_ss` and `ena`=1.
  - Changes of `hh`, `mm` or `pm` alone never trigger.
- Capture:
  - If IDLE, a trigger loads the snapshot register (`pm`, `hh`, `mm`, `ss`) and starts a frame.
  - If busy, a trigger loads the pending-snapshot register and sets pending. A later trigger while busy overwrites the pending snapshot, so only the latest value is kept and the queue is one deep.
- Frame content: 12 bytes, in this order:
  - H1, H0, `:` (0x3A), M1, M0, `:`, S1, S0.
  - `A` (0x41) or `P` (0x50), then `M` (0x4D).
  - CR (0x0D), LF (0x0A).
- Digit encoding:
  - A BCD nibble 0–9 is sent as 0x30 + nibble.
  - A nibble above 9 is sent as `?` (0x3F). No other range checking is done.
- Byte format:
  - Start bit (0), then 8 data bits LSB first, then stop bit (1).
  - Each bit is held for exactly `CLKS_PER_BIT` cycles.
  - No gap between bytes within a frame.
- FSM states: IDLE, START, DATA (bit index 0–7), STOP, NEXT (byte index 0–11).
  - After the STOP of byte 11, the FSM goes to IDLE and pulses `frame_done`.
  - If pending is set when IDLE is entered, pending clears and the pending snapshot becomes the active snapshot.
- Arithmetic:
  - The bit counter is sized with `$clog2(CLKS_PER_BIT)`.
  - The byte index is 4 bits.
  - No counter is allowed to wrap during a frame.

## Timing
- Start latency:
  - Let `ss` change before rising edge N; the trigger is evaluated on edge N.
  - `txd` goes low and `busy` goes high from edge N+1; `txd` is a registered output.
- Frame length: exactly 12 × 10 × `CLKS_PER_BIT` cycles from the first start-bit edge to the end of the last stop bit.
- End of frame: `frame_done` is high for one cycle, coincident with `busy` falling.
- Back-to-back frames:
  - A pending frame's start bit begins one cycle after `busy` falls.
  - So there is at least 1 idle-high cycle between frames.
- Simultaneous events: if a trigger occurs on the same edge that `frame_done` pulses, it is captured as pending, and the rule above applies.
- Reset mid-frame: `txd` returns high asynchronously, and the remaining bytes and any pending snapshot are discarded.
- Edges after reset:
  - The clock resets to 12:00:00 AM, and `prev_ss` resets to 00, so no frame is sent until `ss` first changes.
  - `ena`=0 suppresses triggers, but a frame already in flight completes.

## Configuration
- `CLK_TX_ZERO_BLANK_EN`
  - Defined: when H1 is 0, it is sent as a space (0x20); for example, hour 09 is sent as ` 9`.
  - Not defined: H1 is always sent as a digit; for example, 09 is sent as `09`.
  - Frame length is the same in both builds.

## Test plan
- `CLKS_PER_BIT`=4; release reset; time 12:00:00 AM → 01 with `ena`=1 → decoded line is `12:00:01AM\r\n`, the frame lasts 480 cycles, and `frame_done` pulses exactly once.
- Drive 09:05:07 PM → line is `09:05:07PM\r\n`; with `CLK_TX_ZERO_BLANK_EN` the line is ` 9:05:07PM\r\n`.
- Change `ss` twice while busy (to 02, then 03) → after the current frame there is exactly one further frame, reporting `:03`, starting one cycle after `busy` falls.
- Set `ena`=0 and toggle `ss` → `txd` stays high and `busy`=0; set `ena`=1 during a frame → the frame completes unaltered.
- Assert `reset` low in the middle of byte 5 → `txd`=1 and `busy`=0 immediately; after release, no frame until `ss` next changes.
- Drive `hh`=8'h1A, then change `ss` → the H0 character is `?` (0x3F).
